// File: rtl/set_seq_pkg.sv
// Shared definitions for the SET command sequencer: field widths, FSM encoding
// and the packed command entry stored in the command FIFO.
package set_seq_pkg;

  localparam int CENTRAL_SZ = 24;
  localparam int RADIUS_SZ  = 12;
  localparam int MODE_SZ    = 2;
  localparam int CAND_SZ    = 8;
  localparam int TAG_SZ     = 8;
  localparam int ENTRY_W    = CENTRAL_SZ + RADIUS_SZ + MODE_SZ;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_e;

  // Field order gives the {mode, radius, central} packing of a FIFO entry.
  typedef struct packed {
    logic [MODE_SZ-1:0]    mode;
    logic [RADIUS_SZ-1:0]  radius;
    logic [CENTRAL_SZ-1:0] central;
  } cmd_t;

  function automatic cmd_t pack_cmd(input logic [CENTRAL_SZ-1:0] central,
                                    input logic [RADIUS_SZ-1:0]  radius,
                                    input logic [MODE_SZ-1:0]    mode);
    cmd_t c;
    c.central = central;
    c.radius  = radius;
    c.mode    = mode;
    return c;
  endfunction

endpackage

// File: rtl/set_cmd_fifo.sv
// Synchronous command FIFO with asynchronous active-low reset. DEPTH must be a
// power of two so the read/write pointers wrap naturally.
module set_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 38,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/set_seq.sv
// Command sequencer in front of the SET core: buffers queries, issues them one
// at a time, and returns tagged results (or a forced error on watchdog expiry).
module set_seq
  import set_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023,
  parameter int TMO_W   = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [CENTRAL_SZ-1:0] cmd_central_i,
  input  logic [RADIUS_SZ-1:0]  cmd_radius_i,
  input  logic [MODE_SZ-1:0]    cmd_mode_i,
  output logic                  set_en_o,
  output logic [CENTRAL_SZ-1:0] set_central_o,
  output logic [RADIUS_SZ-1:0]  set_radius_o,
  output logic [MODE_SZ-1:0]    set_mode_o,
  input  logic                  set_busy_i,
  input  logic                  set_valid_i,
  input  logic [CAND_SZ-1:0]    set_candidate_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [CAND_SZ-1:0]    res_candidate_o,
  output logic [TAG_SZ-1:0]     res_tag_o,
  output logic                  res_err_o,
  output seq_state_e            dbg_state_o,
  output logic [$clog2(DEPTH):0] dbg_count_o
);

  // Handshakes: a transfer happens in a cycle where valid and ready are both 1
  // at the rising clock edge; valid never waits on ready, and once res_valid_o
  // rises the result fields stay frozen until that transfer.

  localparam int CNT_W = $clog2(DEPTH) + 1;

  seq_state_e            state_q, state_d;
  logic                  set_en_q, set_en_d;
  logic [CENTRAL_SZ-1:0] central_q, central_d;
  logic [RADIUS_SZ-1:0]  radius_q, radius_d;
  logic [MODE_SZ-1:0]    mode_q, mode_d;
  logic                  res_valid_q, res_valid_d;
  logic [CAND_SZ-1:0]    res_cand_q, res_cand_d;
  logic [TAG_SZ-1:0]     res_tag_q, res_tag_d;
  logic                  res_err_q, res_err_d;
  logic [TMO_W-1:0]      wdog_q, wdog_d;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [ENTRY_W-1:0]    fifo_dout;
  logic                  fifo_pop;
  cmd_t                  head;
  cmd_t                  cmd_in;

  assign cmd_in = pack_cmd(cmd_central_i, cmd_radius_i, cmd_mode_i);
  assign head   = cmd_t'(fifo_dout);

  set_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cmd_valid_i),
    .data_i  (cmd_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign cmd_ready_o     = !fifo_full;
  assign set_en_o        = set_en_q;
  assign set_central_o   = central_q;
  assign set_radius_o    = radius_q;
  assign set_mode_o      = mode_q;
  assign res_valid_o     = res_valid_q;
  assign res_candidate_o = res_cand_q;
  assign res_tag_o       = res_tag_q;
  assign res_err_o       = res_err_q;
  assign dbg_state_o     = state_q;
  assign dbg_count_o     = fifo_count;

  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    set_en_d    = 1'b0;
    central_d   = central_q;
    radius_d    = radius_q;
    mode_d      = mode_q;
    res_valid_d = res_valid_q;
    res_cand_d  = res_cand_q;
    res_tag_d   = res_tag_q;
    res_err_d   = res_err_q;
    wdog_d      = wdog_q;

    case (state_q)
      ST_IDLE: begin
        // set_en_q is registered, so raising it here makes it high only in ISSUE.
        if (!fifo_empty && !set_busy_i) begin
          fifo_pop  = 1'b1;
          central_d = head.central;
          radius_d  = head.radius;
          mode_d    = head.mode;
          set_en_d  = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Watchdog holds j in the j-th WAIT cycle, so TIMEOUT cycles end at TIMEOUT-1.
        if (set_valid_i) begin
          res_cand_d  = set_candidate_i;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else if (wdog_q == TMO_W'(TIMEOUT - 1)) begin
          res_cand_d  = '0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          wdog_d = wdog_q + TMO_W'(1);
        end
      end
      ST_HOLD: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          res_tag_d   = res_tag_q + TAG_SZ'(1);
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      set_en_q    <= 1'b0;
      central_q   <= '0;
      radius_q    <= '0;
      mode_q      <= '0;
      res_valid_q <= 1'b0;
      res_cand_q  <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      set_en_q    <= set_en_d;
      central_q   <= central_d;
      radius_q    <= radius_d;
      mode_q      <= mode_d;
      res_valid_q <= res_valid_d;
      res_cand_q  <= res_cand_d;
      res_tag_q   <= res_tag_d;
      res_err_q   <= res_err_d;
      wdog_q      <= wdog_d;
    end
  end

endmodule

// File: tb/tb_set_seq.sv
// Self-checking bench for set_seq: a behavioural SET core plus a queue-based
// reference of the command FIFO and result stream, with directed and random traffic.
module tb_set_seq;
  import set_seq_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 1023;
  localparam int TMO_W   = 10;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b0;
  logic                  cmd_valid_i = 1'b0;
  logic                  cmd_ready_o;
  logic [CENTRAL_SZ-1:0] cmd_central_i = '0;
  logic [RADIUS_SZ-1:0]  cmd_radius_i = '0;
  logic [MODE_SZ-1:0]    cmd_mode_i = '0;
  logic                  set_en_o;
  logic [CENTRAL_SZ-1:0] set_central_o;
  logic [RADIUS_SZ-1:0]  set_radius_o;
  logic [MODE_SZ-1:0]    set_mode_o;
  logic                  set_busy_i = 1'b0;
  logic                  set_valid_i = 1'b0;
  logic [CAND_SZ-1:0]    set_candidate_i = '0;
  logic                  res_valid_o;
  logic                  res_ready_i = 1'b0;
  logic [CAND_SZ-1:0]    res_candidate_o;
  logic [TAG_SZ-1:0]     res_tag_o;
  logic                  res_err_o;
  seq_state_e            dbg_state_o;
  logic [$clog2(DEPTH):0] dbg_count_o;

  set_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .cmd_valid_i     (cmd_valid_i),
    .cmd_ready_o     (cmd_ready_o),
    .cmd_central_i   (cmd_central_i),
    .cmd_radius_i    (cmd_radius_i),
    .cmd_mode_i      (cmd_mode_i),
    .set_en_o        (set_en_o),
    .set_central_o   (set_central_o),
    .set_radius_o    (set_radius_o),
    .set_mode_o      (set_mode_o),
    .set_busy_i      (set_busy_i),
    .set_valid_i     (set_valid_i),
    .set_candidate_i (set_candidate_i),
    .res_valid_o     (res_valid_o),
    .res_ready_i     (res_ready_i),
    .res_candidate_o (res_candidate_o),
    .res_tag_o       (res_tag_o),
    .res_err_o       (res_err_o),
    .dbg_state_o     (dbg_state_o),
    .dbg_count_o     (dbg_count_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [7:0] cand;
    logic [7:0] tag;
    logic       err;
    int         due;
  } res_t;

  cmd_t       exp_q[$];
  res_t       res_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  logic [7:0] tag_model = '0;
  bit         hang = 0;
  int         force_cand = -1;
  int         force_delay = -1;
  bit         pend = 0;
  int         valid_at = 0;
  logic [7:0] pend_cand = '0;
  int         spur_req = 0;
  bit         prev_en = 0;
  bit         prev_busy = 0;
  int         last_hs = -10;
  int         last_push = -10;
  bit         lat_chk = 0;
  int         n_pushed = 0;
  int         n_results = 0;
  logic [7:0] last_tag = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- monitor + reference model (samples at negedge) ----------------
  initial begin
    cmd_t       e;
    res_t       r;
    int         d;
    logic [7:0] c;
    bit         exp_v;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_i) begin
        check("rst_en", set_en_o, 0);
        check("rst_central", set_central_o, 0);
        check("rst_radius", set_radius_o, 0);
        check("rst_mode", set_mode_o, 0);
        check("rst_res_valid", res_valid_o, 0);
        check("rst_res_cand", res_candidate_o, 0);
        check("rst_res_tag", res_tag_o, 0);
        check("rst_res_err", res_err_o, 0);
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_count", dbg_count_o, 0);
        exp_q.delete();
        res_q.delete();
        tag_model = '0;
        pend      = 0;
        prev_en   = 0;
        prev_busy = 0;
        last_hs   = -10;
      end else begin
        if (set_en_o) begin
          check("en_single", prev_en, 0);
          check("en_busy", prev_busy, 0);
          check("en_one_in_flight", res_q.size(), 0);
          check("en_after_hs", (cyc >= last_hs + 2), 1);
          if (lat_chk) begin
            check("en_latency", cyc, last_push + 2);
            lat_chk = 0;
          end
          if (exp_q.size() == 0) begin
            check("en_without_cmd", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("issue_central", set_central_o, e.central);
            check("issue_radius", set_radius_o, e.radius);
            check("issue_mode", set_mode_o, e.mode);
            r.tag = tag_model;
            if (hang) begin
              r.cand = '0;
              r.err  = 1'b1;
              r.due  = cyc + 1 + TIMEOUT;
            end else begin
              d = (force_delay > 0) ? force_delay : $urandom_range(1, 25);
              c = (force_cand >= 0) ? force_cand[7:0] : 8'($urandom);
              pend      = 1;
              valid_at  = cyc + d;
              pend_cand = c;
              r.cand = c;
              r.err  = 1'b0;
              r.due  = cyc + d + 1;
            end
            res_q.push_back(r);
            tag_model = tag_model + 8'd1;
          end
        end
        if (pend && cyc == valid_at) pend = 0;

        exp_v = (res_q.size() > 0) && (cyc >= res_q[0].due);
        check("res_valid", res_valid_o, exp_v);
        if (exp_v && res_valid_o) begin
          check("res_cand", res_candidate_o, res_q[0].cand);
          check("res_tag", res_tag_o, res_q[0].tag);
          check("res_err", res_err_o, res_q[0].err);
          if (res_ready_i) begin
            last_tag = res_tag_o;
            void'(res_q.pop_front());
            last_hs = cyc;
            n_results++;
          end
        end

        check("cmd_ready", cmd_ready_o, (exp_q.size() < DEPTH));
        check("fifo_count", dbg_count_o, exp_q.size());
        if (cmd_valid_i && cmd_ready_o) begin
          exp_q.push_back(pack_cmd(cmd_central_i, cmd_radius_i, cmd_mode_i));
          last_push = cyc;
          n_pushed++;
        end
        prev_en   = set_en_o;
        prev_busy = set_busy_i;
      end
    end
  end

  // ---------------- behavioural SET core (drives after posedge) ----------------
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      set_valid_i     = 1'b0;
      set_candidate_i = 8'($urandom);
      if (pend && (cyc + 1 == valid_at)) begin
        set_valid_i     = 1'b1;
        set_candidate_i = pend_cand;
      end else if (spur_req > 0) begin
        set_valid_i = 1'b1;
        spur_req--;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_cmd(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    bit acc;
    acc           = 0;
    cmd_valid_i   = 1'b1;
    cmd_central_i = c;
    cmd_radius_i  = r;
    cmd_mode_i    = m;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk_i);
      acc = cmd_ready_o;
      tick();
    end
    cmd_valid_i = 1'b0;
    if (!acc) check("push_timeout", 0, 1);
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      if (exp_q.size() == 0 && res_q.size() == 0) done = 1;
      else tick();
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    repeat (3) tick();
    rst_i       = 1'b1;
    res_ready_i = 1'b1;
    tick();

    // single directed query, fixed 20-cycle core latency
    force_delay = 20;
    force_cand  = 17;
    lat_chk     = 1;
    push_cmd(24'h123456, 12'h345, 2'd1);
    wait_drain(200);
    force_delay = -1;
    force_cand  = -1;
    check("single_tag", last_tag, 0);

    // random traffic with random busy and consumer stalls
    n0 = n_pushed;
    for (int i = 0; i < 4000 && (n_pushed - n0) < 40; i++) begin
      cmd_valid_i   = ($urandom_range(0, 9) < 4);
      cmd_central_i = 24'($urandom);
      cmd_radius_i  = 12'($urandom);
      cmd_mode_i    = 2'($urandom);
      set_busy_i    = ($urandom_range(0, 9) < 3);
      res_ready_i   = ($urandom_range(0, 9) < 6);
      tick();
    end
    cmd_valid_i = 1'b0;
    set_busy_i  = 1'b0;
    res_ready_i = 1'b1;
    wait_drain(3000);

    // fill: five back-to-back pushes with the core busy
    set_busy_i = 1'b1;
    n0 = n_pushed;
    for (int i = 0; i < 5; i++) begin
      cmd_valid_i   = 1'b1;
      cmd_central_i = 24'($urandom);
      cmd_radius_i  = 12'($urandom);
      cmd_mode_i    = 2'($urandom);
      @(negedge clk_i);
      check("fill_ready", cmd_ready_o, (i < 4));
      tick();
    end
    cmd_valid_i = 1'b0;
    check("fill_accepted", n_pushed - n0, 4);
    repeat (5) tick();
    set_busy_i = 1'b0;
    wait_drain(500);

    // backpressure: consumer stalls with two queued commands
    res_ready_i = 1'b0;
    push_cmd(24'hABCDEF, 12'h111, 2'd2);
    push_cmd(24'h0F0F0F, 12'h222, 2'd3);
    repeat (60) tick();
    @(negedge clk_i);
    check("bp_res_valid", res_valid_o, 1);
    check("bp_queued", dbg_count_o, 1);
    tick();
    res_ready_i = 1'b1;
    wait_drain(300);

    // watchdog: core never answers
    hang = 1;
    push_cmd(24'h777777, 12'h777, 2'd0);
    wait_drain(1300);
    hang = 0;

    // spurious valid in IDLE, then busy with a queued command
    spur_req = 1;
    repeat (4) tick();
    set_busy_i = 1'b1;
    push_cmd(24'h555555, 12'h555, 2'd1);
    spur_req = 1;
    repeat (10) tick();
    @(negedge clk_i);
    check("busy_no_en", set_en_o, 0);
    check("busy_queued", dbg_count_o, 1);
    tick();
    set_busy_i = 1'b0;
    wait_drain(200);

    // reset while waiting on the core
    hang = 1;
    push_cmd(24'h999999, 12'h999, 2'd2);
    repeat (10) tick();
    rst_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b1;
    hang  = 0;
    repeat (2) tick();

    // tag wrap: 257 completed queries after reset
    n0 = n_results;
    for (int q = 0; q < 257; q++) begin
      push_cmd(24'($urandom), 12'($urandom), 2'($urandom));
      wait_drain(100);
    end
    check("wrap_count", n_results - n0, 257);
    check("wrap_tag", last_tag, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
